// File: rtl/led_pattern_decoder.sv
// rtl/led_pattern_decoder.sv - identifies and tracks the running LED shift pattern
//
// Watches a 16-bit LED bus, sampled on led_valid strobes, and works out which
// pattern is running: right shift, left shift, inside-out, outside-in, or blink.
// Once locked, it tracks the phase, pulses wrap at each period boundary and
// counts every step that breaks the sequence.
//
// Optional feature macro: LED_DEC_BLINK_EN. When it is defined, the decoder
// also recognises the 0xFFFF/0x0000 blink pattern. When it is undefined, the
// blink logic is removed and the blink output is tied to 0.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   led_in     LED bus value
//   led_valid  one-cycle strobe; led_in is sampled on this cycle
//   clear_err  synchronous clear of err_cnt
//   locked     a pattern has been identified and is being tracked
//   mode_out   0=right(>>), 1=left(<<), 2=inside-out, 3=outside-in
//   blink      blink pattern locked (mode_out is forced to 0)
//   phase      step index within the pattern period
//   wrap       one-cycle pulse when phase returns to 0 while locked
//   err        one-cycle pulse on a sequence mismatch
//   err_cnt    saturating count of mismatches
module led_pattern_decoder #(
  parameter int LOCK_MISS = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          led_in,
  input  logic                 led_valid,
  input  logic                 clear_err,
  output logic                 locked,
  output logic [1:0]           mode_out,
  output logic                 blink,
  output logic [3:0]           phase,
  output logic                 wrap,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK, S_ERR} state_t;

  state_t      state, state_n;
  logic [15:0] prev_q, prev_n;
  logic [2:0]  miss_q, miss_n, miss_inc;
  logic        locked_n, wrap_n, err_n, cnt_inc;
  logic [1:0]  mode_n, acq_mode;
  logic [3:0]  phase_n, acq_phase, lock_phase, blink_phase;
  logic [3:0]  hit;
  logic        blink_hit, acq_match, lock_match;

  function automatic logic is_onehot(input logic [15:0] x);
    return (x != 16'h0000) && ((x & (x - 16'd1)) == 16'h0000);
  endfunction

  // The symmetric patterns (inside-out and outside-in) share one set of legal values.
  function automatic logic is_sym(input logic [15:0] x);
    logic r;
    case (x)
      16'h0180, 16'h0240, 16'h0420, 16'h0810,
      16'h1008, 16'h2004, 16'h4002, 16'h8001: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] nxt(input logic [1:0] m, input logic [15:0] x);
    logic [15:0] r;
    case (m)
      2'd0:    r = (x == 16'h0001) ? 16'h8000 : {1'b0, x[15:1]};
      2'd1:    r = (x == 16'h8000) ? 16'h0001 : {x[14:0], 1'b0};
      2'd2:    r = (x == 16'h8001) ? 16'h0180 : {x[14:8], 1'b0, 1'b0, x[7:1]};
      default: r = (x == 16'h0180) ? 16'h8001 : {1'b0, x[15:9], x[6:0], 1'b0};
    endcase
    return r;
  endfunction

  // A step only counts when the previous value is itself legal for the mode.
  // Without this, an illegal value such as 0x0003 could still shift into a
  // legal one.
  function automatic logic fits(input logic [1:0] m, input logic [15:0] p,
                                input logic [15:0] c);
    logic legal;
    legal = m[1] ? is_sym(p) : is_onehot(p);
    return legal && (c == nxt(m, p));
  endfunction

  // Priority encoder: returns the index of the highest set bit.
  function automatic logic [3:0] hi_idx(input logic [15:0] x);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) r = i[3:0];
    end
    return r;
  endfunction

  // For the symmetric patterns, the upper-half bit position locates the step.
  // Inside-out starts at bit 8 (0x0180). Outside-in starts at bit 15 (0x8001).
  function automatic logic [3:0] phase_of(input logic [1:0] m, input logic [15:0] x);
    logic [3:0] h;
    logic [3:0] r;
    h = hi_idx(x);
    case (m)
      2'd0:    r = 4'd15 - h;
      2'd1:    r = h;
      2'd2:    r = h - 4'd8;
      default: r = 4'd15 - h;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int m = 0; m < 4; m++) begin
      hit[m] = fits(m[1:0], prev_q, led_in);
    end
  end

`ifdef LED_DEC_BLINK_EN
  logic blink_n;
  assign blink_hit = ((prev_q == 16'hFFFF) || (prev_q == 16'h0000)) && (led_in == ~prev_q);
`else
  assign blink_hit = 1'b0;
  assign blink     = 1'b0;
`endif

  // The candidate pairs are disjoint, so at most one hit bit can be set.
  always_comb begin
    acq_mode = 2'd0;
    if (hit[1]) acq_mode = 2'd1;
    if (hit[2]) acq_mode = 2'd2;
    if (hit[3]) acq_mode = 2'd3;
  end

  assign blink_phase = (led_in == 16'hFFFF) ? 4'd0 : 4'd1;
  assign acq_match   = (|hit) || blink_hit;
  assign acq_phase   = blink_hit ? blink_phase : phase_of(acq_mode, led_in);
  assign lock_match  = blink ? blink_hit : hit[mode_out];
  assign lock_phase  = blink ? blink_phase : phase_of(mode_out, led_in);
  assign miss_inc    = miss_q + 3'd1;

  always_comb begin
    state_n  = state;
    prev_n   = prev_q;
    miss_n   = miss_q;
    locked_n = locked;
    mode_n   = mode_out;
    phase_n  = phase;
    wrap_n   = 1'b0;
    err_n    = 1'b0;
    cnt_inc  = 1'b0;
`ifdef LED_DEC_BLINK_EN
    blink_n  = blink;
`endif
    if (led_valid) begin
      prev_n = led_in;
      case (state)
        S_IDLE: state_n = S_ACQ;
        S_ACQ: begin
          if (acq_match) begin
            state_n  = S_LOCK;
            locked_n = 1'b1;
            miss_n   = 3'd0;
            mode_n   = blink_hit ? 2'd0 : acq_mode;
            phase_n  = acq_phase;
`ifdef LED_DEC_BLINK_EN
            blink_n  = blink_hit;
`endif
          end
        end
        S_LOCK: begin
          if (lock_match) begin
            miss_n  = 3'd0;
            phase_n = lock_phase;
            wrap_n  = (lock_phase == 4'd0);
          end else begin
            err_n   = 1'b1;
            cnt_inc = 1'b1;
            if (miss_inc >= LOCK_MISS[2:0]) begin
              miss_n   = 3'd0;
              state_n  = S_ERR;
              locked_n = 1'b0;
            end else begin
              miss_n = miss_inc;
            end
          end
        end
        S_ERR: state_n = S_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      prev_q   <= 16'h0000;
      miss_q   <= 3'd0;
      locked   <= 1'b0;
      mode_out <= 2'd0;
      phase    <= 4'd0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      prev_q   <= prev_n;
      miss_q   <= miss_n;
      locked   <= locked_n;
      mode_out <= mode_n;
      phase    <= phase_n;
      wrap     <= wrap_n;
      err      <= err_n;
    end
  end

`ifdef LED_DEC_BLINK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blink <= 1'b0;
    else      blink <= blink_n;
  end
`endif

  // A clear that coincides with an increment leaves the new mismatch counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (clear_err) begin
      err_cnt <= cnt_inc ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (cnt_inc && !(&err_cnt)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_led_pattern_decoder.sv
// tb/tb_led_pattern_decoder.sv - directed self-checking bench for led_pattern_decoder
module tb_led_pattern_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] led_in = 16'h0000;
  logic        led_valid = 1'b0;
  logic        clear_err = 1'b0;
  logic        locked, blink, wrap, err;
  logic [1:0]  mode_out;
  logic [3:0]  phase;
  logic [7:0]  err_cnt;

  int n_run  = 0;
  int n_fail = 0;

  led_pattern_decoder #(.LOCK_MISS(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .led_valid(led_valid),
    .clear_err(clear_err), .locked(locked), .mode_out(mode_out),
    .blink(blink), .phase(phase), .wrap(wrap), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; led_valid = 1'b0; clear_err = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  // The strobe is applied for one cycle. Outputs are then checked at the next
  // falling edge, after the posedge has registered them.
  task automatic step_c(input logic [15:0] v, input logic c);
    @(negedge clk);
    led_in = v; led_valid = 1'b1; clear_err = c;
    @(negedge clk);
    led_valid = 1'b0; clear_err = 1'b0;
  endtask

  task automatic step(input logic [15:0] v);
    step_c(v, 1'b0);
  endtask

  initial begin
    // 1: right shift, acquisition, phase and wrap
    do_reset();
    check_eq("reset_outputs", {locked, mode_out, blink, phase, wrap, err, err_cnt}, 32'h0);
    step(16'h8000);
    check_eq("m0_first_unlocked", locked, 1'b0);
    step(16'h4000);
    check_eq("m0_lock", {locked, mode_out, phase}, {1'b1, 2'd0, 4'd1});
    step(16'h2000);
    check_eq("m0_phase2", phase, 4'd2);
    for (int i = 3; i < 16; i++) step(16'h8000 >> i);
    check_eq("m0_phase15", {phase, wrap}, {4'd15, 1'b0});
    step(16'h8000);
    check_eq("m0_wrap", {wrap, phase, locked}, {1'b1, 4'd0, 1'b1});
    @(negedge clk);
    check_eq("m0_wrap_clears", wrap, 1'b0);

    // 2: inside-out with wrap, then outside-in acquisition
    do_reset();
    step(16'h0180);
    step(16'h0240);
    check_eq("m2_lock", {locked, mode_out, phase}, {1'b1, 2'd2, 4'd1});
    step(16'h0420); step(16'h0810); step(16'h1008);
    step(16'h2004); step(16'h4002); step(16'h8001);
    check_eq("m2_phase7", {phase, wrap, err}, {4'd7, 1'b0, 1'b0});
    step(16'h0180);
    check_eq("m2_wrap", {wrap, phase}, {1'b1, 4'd0});
    do_reset();
    step(16'h8001);
    step(16'h4002);
    check_eq("m3_lock", {locked, mode_out, phase}, {1'b1, 2'd3, 4'd1});

    // 3: errors in left shift, drop to ERR, then relock
    do_reset();
    step(16'h0001); step(16'h0002); step(16'h0004);
    check_eq("m1_lock", {locked, mode_out, phase}, {1'b1, 2'd1, 4'd2});
    step(16'h0003);
    check_eq("m1_err1", {err, err_cnt, locked, phase}, {1'b1, 8'd1, 1'b1, 4'd2});
    step(16'h0008);
    check_eq("m1_err2_drop", {err, err_cnt, locked}, {1'b1, 8'd2, 1'b0});
    step(16'h0010);
    check_eq("err_to_acq", {locked, err}, {1'b0, 1'b0});
    step(16'h0020);
    check_eq("m1_relock", {locked, mode_out, phase, err_cnt}, {1'b1, 2'd1, 4'd5, 8'd2});

    // 4: blink pattern
    do_reset();
    step(16'hFFFF);
    step(16'h0000);
`ifdef LED_DEC_BLINK_EN
    check_eq("blink_lock", {locked, blink, mode_out, phase}, {1'b1, 1'b1, 2'd0, 4'd1});
    step(16'hFFFF);
    check_eq("blink_wrap", {phase, wrap}, {4'd0, 1'b1});
`else
    step(16'hFFFF);
    check_eq("blink_disabled", {locked, blink}, {1'b0, 1'b0});
`endif

    // 5: gaps without strobe, then asynchronous reset between edges
    do_reset();
    step(16'h8000); step(16'h4000);
    led_in = 16'h1234;
    repeat (3) @(negedge clk);
    check_eq("gap_hold", {locked, mode_out, phase, wrap, err}, {1'b1, 2'd0, 4'd1, 1'b0, 1'b0});
    step(16'h2000);
    check_eq("gap_resume", {locked, phase, err}, {1'b1, 4'd2, 1'b0});
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_eq("async_reset", {locked, mode_out, blink, phase, wrap, err, err_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // 6: saturation and clear_err
    step(16'h0001);
    for (int i = 0; i < 150; i++) begin
      step(16'h0002); step(16'h0003); step(16'h0003); step(16'h0001);
      if (i == 99) check_eq("err_cnt_200", err_cnt, 8'd200);
    end
    step(16'h0002);
    check_eq("err_cnt_sat", {err_cnt, locked}, {8'd255, 1'b1});
    step_c(16'h0003, 1'b1);
    check_eq("clear_with_inc", {err_cnt, err}, {8'd1, 1'b1});
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    check_eq("clear_alone", err_cnt, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
